// File: rtl/picorv32_trace_pkg.sv
// Purpose: shared types and constants for the picorv32 trace capture controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package picorv32_trace_pkg;

  // Default width of one core trace word.
  localparam int TRACE_W_DEF = 36;

  // Width of the saturating dropped-word counter.
  localparam int DROP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

endpackage

// File: rtl/picorv32_trace_fifo.sv
// Purpose: trace word FIFO with a registered read port (head word held in a flop).
// Latency: a pushed word appears on rd_valid/rd_data one cycle after the push, never combinationally.
// Backpressure: caller must not push when full unless it pops in the same cycle; rd_data holds while not popped.
//
// Ports:
//   clk, resetn         clock, async active-low reset
//   push, wr_data       write strobe and word
//   pop                 consume the head word (only when rd_valid)
//   rd_valid, rd_data   head word, registered
//   full, empty, level  occupancy flags and count (includes the head word)
module picorv32_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 36,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] head_idx;
  logic [LW-1:0] level_next;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + 1'b1;
    end else if (!push && pop) begin
      level_next = level - 1'b1;
    end
    // Slot that will be the head after this edge.
    head_idx = pop ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Head register: when the next head is the word being written this cycle
  // (FIFO empty after the pop), forward it from wr_data into the flop, so it
  // still shows up only in the following cycle.
  always_ff @(posedge clk) begin
    if (level_next != '0) begin
      rd_data <= (push && (head_idx == wr_ptr)) ? wr_data : mem[head_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level    <= level_next;
      rd_valid <= (level_next != '0);
    end
  end

endmodule

// File: rtl/picorv32_trace_ctrl.sv
// Purpose: arms on a pulse, captures core trace words into a FIFO until trap, then drains to done.
// Latency: trace word to out_valid/out_data is one cycle minimum (registered FIFO head).
// Backpressure: out_ready stalls the drain; pushes into a full FIFO without a pop are dropped and counted.
//
// Ports:
//   clk, resetn                 clock, async active-low reset
//   arm                         start a capture session (honoured in IDLE or DONE)
//   trace_valid, trace_data     core trace stream
//   trap                        ends the capture window
//   out_valid/out_data/out_ready drain stream
//   capturing, done             state indications
//   overflow, drop_count        per-session drop statistics
//   level                       FIFO occupancy
module picorv32_trace_ctrl
  import picorv32_trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TRACE_W = TRACE_W_DEF,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               arm,
  input  logic               trace_valid,
  input  logic [TRACE_W-1:0] trace_data,
  input  logic               trap,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TRACE_W-1:0] out_data,
  output logic               capturing,
  output logic               done,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  output logic [LW-1:0]      level
);

  trace_state_t state;
  logic         pop;
  logic         push_req;
  logic         push_acc;
  logic         fifo_full;
  logic         fifo_empty;
  logic         session_start;

  assign pop           = out_valid & out_ready;
  assign push_req      = (state == ST_CAPTURE) & trace_valid;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign push_acc      = push_req & (~fifo_full | pop);
  assign session_start = arm & ((state == ST_IDLE) | (state == ST_DONE));

  picorv32_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (TRACE_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push_acc),
    .wr_data  (trace_data),
    .pop      (pop),
    .rd_valid (out_valid),
    .rd_data  (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      capturing <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state     <= ST_CAPTURE;
            capturing <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (trap) begin
            state     <= ST_DRAIN;
            capturing <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // level is registered, so this fires the cycle after it hits 0.
          if (fifo_empty) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          capturing <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (session_start) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (push_req && !push_acc) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_picorv32_trace_ctrl.sv
// Purpose: randomized and directed bench for picorv32_trace_ctrl against a queue-based reference model.
// Latency: n/a.
// Backpressure: out_ready driven by directed phases and randomly.
module tb_picorv32_trace_ctrl;

  localparam int DEPTH = 16;
  localparam int TW    = 36;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          arm;
  logic          trace_valid;
  logic [TW-1:0] trace_data;
  logic          trap;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          capturing;
  logic          done;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [LW-1:0] level;

  picorv32_trace_ctrl #(.DEPTH(DEPTH), .TRACE_W(TW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .arm         (arm),
    .trace_valid (trace_valid),
    .trace_data  (trace_data),
    .trap        (trap),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .capturing   (capturing),
    .done        (done),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .level       (level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered words as a queue, session phase as flags.
  logic [TW-1:0] m_q[$];
  bit            m_cap, m_drn, m_dn;
  bit            m_ovf;
  int            m_drop;

  // Words actually handed over by the DUT, and words the bench sent.
  logic [TW-1:0] dut_q[$];
  logic [TW-1:0] sent_q[$];
  logic          last_v;
  logic [TW-1:0] last_d;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cap  = 0;
    m_drn  = 0;
    m_dn   = 0;
    m_ovf  = 0;
    m_drop = 0;
    last_v = 1'b0;
  endtask

  task automatic model_edge();
    int sz0;
    bit pop, acc;
    sz0 = m_q.size();
    pop = (sz0 > 0) && out_ready;
    acc = 0;
    if (m_cap && trace_valid) begin
      if (sz0 < DEPTH || pop) acc = 1;
      else begin
        m_ovf = 1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(trace_data);
    if (!m_cap && !m_drn && arm) begin
      m_cap = 1; m_dn = 0; m_ovf = 0; m_drop = 0;
    end else if (m_cap && trap) begin
      m_cap = 0; m_drn = 1;
    end else if (m_drn && sz0 == 0) begin
      m_drn = 0; m_dn = 1;
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_q.size() > 0));
    chk("level", 64'(level), 64'(m_q.size()));
    chk("capturing", 64'(capturing), 64'(m_cap));
    chk("done", 64'(done), 64'(m_dn));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    if (m_q.size() > 0) chk("out_data", 64'(out_data), 64'(m_q[0]));
    last_v = out_valid;
    last_d = out_data;
  endtask

  // One clock: DUT and model advance on the rising edge, check on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (last_v === 1'b1 && out_ready) dut_q.push_back(last_d);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic push_word(input logic [TW-1:0] d);
    trace_valid = 1'b1;
    trace_data  = d;
    tick();
    trace_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_trap();
    trap = 1'b1;
    tick();
    trap = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && done !== 1'b1; i++) tick();
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    resetn      = 1'b0;
    arm         = 1'b0;
    trace_valid = 1'b0;
    trace_data  = '0;
    trap        = 1'b0;
    out_ready   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_capturing", 64'(capturing), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);

    // Arm in the very first cycle after reset release.
    resetn = 1'b1;
    do_arm();
    chk("first_arm", 64'(capturing), 64'd1);

    // Basic capture of 0x1..0x5.
    out_ready = 1'b1;
    dut_q.delete();
    for (int i = 1; i <= 5; i++) push_word(TW'(i));
    do_trap();
    wait_done("basic");
    chk("basic_cnt", 64'(dut_q.size()), 64'd5);
    for (int i = 0; i < dut_q.size() && i < 5; i++) chk("basic_word", 64'(dut_q[i]), 64'(i + 1));
    chk("basic_drop", 64'(drop_count), 64'd0);

    // Overflow: 20 words into 16 entries with the drain stalled.
    do_arm();
    out_ready = 1'b0;
    dut_q.delete();
    for (int i = 0; i < 20; i++) push_word(TW'(100 + i));
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_drop", 64'(drop_count), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 40 && level != 0; i++) tick();
    tick();
    chk("ovf_cnt", 64'(dut_q.size()), 64'd16);
    for (int i = 0; i < dut_q.size() && i < 16; i++) chk("ovf_word", 64'(dut_q[i]), 64'(100 + i));

    // Full FIFO with simultaneous push and pop.
    out_ready = 1'b0;
    dut_q.delete();
    for (int i = 0; i < 16; i++) push_word(TW'(200 + i));
    chk("full_level", 64'(level), 64'd16);
    out_ready = 1'b1;
    push_word(TW'(300));
    chk("pp_level", 64'(level), 64'd16);
    chk("pp_drop", 64'(drop_count), 64'd4);
    do_trap();
    wait_done("pp");
    chk("pp_cnt", 64'(dut_q.size()), 64'd17);
    if (dut_q.size() > 0) chk("pp_last", 64'(dut_q[dut_q.size() - 1]), 64'd300);

    // Trap together with trace_valid; arm pulsed in DRAIN must be ignored.
    do_arm();
    out_ready = 1'b0;
    dut_q.delete();
    for (int i = 0; i < 3; i++) push_word(TW'(16 + i));
    trace_valid = 1'b1; trace_data = TW'(12'hAAA); trap = 1'b1;
    tick();
    trap = 1'b0; trace_data = TW'(12'hBBB);
    tick();
    trace_valid = 1'b0;
    chk("trap_level", 64'(level), 64'd4);
    do_arm();
    chk("drain_arm_ignored", 64'(capturing), 64'd0);
    wait_done("trap");
    chk("trap_cnt", 64'(dut_q.size()), 64'd4);
    if (dut_q.size() > 0) chk("trap_last", 64'(dut_q[dut_q.size() - 1]), 64'hAAA);

    // Random backpressure, 200 words, level kept below 16.
    do_arm();
    dut_q.delete();
    sent_q.delete();
    for (int cyc = 0; cyc < 3000 && sent_q.size() < 200; cyc++) begin
      out_ready   = ($urandom_range(0, 2) != 0);
      trace_valid = ($urandom_range(0, 1) == 1) && (m_q.size() < 14);
      trace_data  = {4'($urandom), 32'($urandom)};
      if (trace_valid) sent_q.push_back(trace_data);
      tick();
    end
    trace_valid = 1'b0;
    do_trap();
    wait_done("bp");
    chk("bp_cnt", 64'(dut_q.size()), 64'd200);
    for (int i = 0; i < dut_q.size() && i < sent_q.size(); i++) chk("bp_word", 64'(dut_q[i]), 64'(sent_q[i]));

    // Reset in the middle of a drain with 7 words buffered.
    do_arm();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(TW'(50 + i));
    do_trap();
    chk("mid_level", 64'(level), 64'd7);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_level", 64'(level), 64'd0);
    chk("mid_rst_capturing", 64'(capturing), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    dut_q.delete();
    do_arm();
    chk("restart_capturing", 64'(capturing), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_word(TW'(70 + i));
    do_trap();
    wait_done("restart");
    chk("restart_cnt", 64'(dut_q.size()), 64'd3);
    for (int i = 0; i < dut_q.size() && i < 3; i++) chk("restart_word", 64'(dut_q[i]), 64'(70 + i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/picorv32_trace_ctrl.md
PICORV32_TRACE_CTRL -- requirements
Module: picorv32_trace_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, >=4).
REQ-002 SHALL have parameter TRACE_W, default 36, trace word width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port arm  input  1  one-cycle pulse that starts a capture session.
REQ-006 SHALL have port trace_valid  input  1  core trace word valid this cycle.
REQ-007 SHALL have port trace_data  input  TRACE_W  core trace word.
REQ-008 SHALL have port trap  input  1  core trap, ends the capture window.
REQ-009 SHALL have port out_valid  output  1  drain word available.
REQ-010 SHALL have port out_data  output  TRACE_W  drain word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the drain word.
REQ-012 SHALL have port capturing  output  1  high in CAPTURE state.
REQ-013 SHALL have port done  output  1  high in DONE state.
REQ-014 SHALL have port overflow  output  1  sticky; at least one word dropped this session.
REQ-015 SHALL have port drop_count  output  16  dropped words this session, saturating.
REQ-016 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 SHALL implement states IDLE, CAPTURE, DRAIN, DONE.
REQ-018 SHALL go IDLE->CAPTURE on arm, and DONE->CAPTURE on arm.
REQ-019 SHALL go CAPTURE->DRAIN on trap; arm SHALL be ignored in CAPTURE and DRAIN.
REQ-020 SHALL go DRAIN->DONE in the cycle after level reaches 0.
REQ-021 SHALL push trace_data only in CAPTURE with trace_valid=1, including the cycle trap is sampled.
REQ-022 SHALL accept a push when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle.
REQ-023 SHALL drop a rejected push: drop_count+1 saturating at 16'hFFFF, overflow set.
REQ-024 SHALL pop on out_valid && out_ready in any state; the drain runs concurrently with capture.
REQ-025 SHALL present a pushed word on out_valid/out_data no earlier than the cycle after the push (1-cycle minimum latency, no bypass).
REQ-026 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL preserve arrival order; pointers SHALL wrap modulo DEPTH.
REQ-028 SHALL update level by +1 on push only, -1 on pop only, and 0 on push+pop.
REQ-029 SHALL clear overflow and drop_count on entry to CAPTURE; FIFO contents SHALL NOT be cleared by arm.
REQ-030 SHALL assert out_valid=0 whenever level=0.

Reset
REQ-031 SHALL, on resetn low, asynchronously force state IDLE, level 0, pointers 0, out_valid 0, capturing 0, done 0, overflow 0, drop_count 0.
REQ-032 SHALL discard all buffered words on reset mid-session; out_data SHALL need no reset.
REQ-033 SHALL leave reset synchronously; the first arm SHALL be honoured in the first cycle after deassertion.

Structure
REQ-034 SHALL take the state enum, TRACE_W default and the drop-counter width from shared package picorv32_trace_pkg.
REQ-035 SHALL instantiate one sub-module, picorv32_trace_fifo (push/pop/full/empty/level, registered read); FSM and counters SHALL remain in the top block.

Verification
REQ-036 SHALL cover basic capture: arm; 5 trace words 0x1..0x5, out_ready=1; trap -> 0x1..0x5 drained in order, done=1, drop_count=0.
REQ-037 SHALL cover overflow: out_ready=0, 20 consecutive words with DEPTH=16 -> level=16, drop_count=4, overflow=1; releasing out_ready yields the first 16 words only.
REQ-038 SHALL cover full with simultaneous push+pop: level=16, out_ready=1 and trace_valid together -> push accepted, level stays 16, no drop.
REQ-039 SHALL cover trap with trace_valid in the same cycle: that word is captured; a word the cycle after trap is not captured.
REQ-040 SHALL cover backpressure: out_ready toggled randomly for 200 words at level<16 -> no loss or duplication, and out_data stable while stalled.
REQ-041 SHALL cover reset mid-drain: resetn low with level=7 -> out_valid=0, level=0, state IDLE; arm after release restarts cleanly.
